// File: rtl/fios_pe_stream.sv
// fios_pe_stream: one FIOS outer iteration for multiplier word x, streaming Y/n/t
// word-serially and emitting t' = (t + x*Y + m*n) / 2^W as S+1 words.
module fios_pe_stream #(
    parameter int unsigned W = 16,
    parameter int unsigned S = 16
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] n_prime_0_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] y_i,
    input  logic [W-1:0] n_i,
    input  logic [W-1:0] t_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] t_o,
    output logic         out_last_o,
    output logic         busy_o,
    output logic         done_o
);
    localparam int unsigned VW = 2*W + 2;
    localparam int unsigned JW = $clog2(S + 1);

    typedef enum logic [2:0] {
        IDLE,
        FIRST,
        RUN,
        TOP,
        FLUSH,
        DONE_WAIT
    } state_t;

    state_t state, state_nxt;

    logic [W-1:0]  x_q, np_q, m_q;
    logic [W:0]    c_q;
    logic [JW-1:0] j_q;

    logic          in_xfer, out_xfer, out_free;
    logic [W-1:0]  u_lo, m_calc, m_use;
    logic [VW-1:0] xy, mn, v, cin;
    logic [W:0]    c_nxt;

    assign out_free = !out_valid_o || out_ready_i;
    assign in_xfer  = in_valid_i && in_ready_o;
    assign out_xfer = out_valid_o && out_ready_i;

    // Beat arithmetic. FIRST derives m from the low word of t0 + x*y0 and
    // starts from a zero carry; TOP only folds the carry into t_S.
    always_comb begin
        xy     = VW'(x_q) * VW'(y_i);
        u_lo   = t_i + xy[W-1:0];
        m_calc = u_lo * np_q;
        m_use  = (state == FIRST) ? m_calc : m_q;
        mn     = VW'(m_use) * VW'(n_i);
        cin    = (state == FIRST) ? '0 : VW'(c_q);
        if (state == TOP) begin
            v = VW'(t_i) + cin;
        end else begin
            v = VW'(t_i) + xy + mn + cin;
        end
        c_nxt = (W+1)'(v >> W);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (start_i) state_nxt = FIRST;
            FIRST:     if (in_xfer) state_nxt = RUN;
            RUN:       if (in_xfer && (j_q == JW'(S - 1))) state_nxt = TOP;
            TOP:       if (in_xfer) state_nxt = FLUSH;
            FLUSH:     if (out_free) state_nxt = DONE_WAIT;
            DONE_WAIT: if (out_xfer) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o     = (state != IDLE);
        in_ready_o = ((state == FIRST) || (state == RUN) || (state == TOP)) && out_free;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            x_q         <= '0;
            np_q        <= '0;
            m_q         <= '0;
            c_q         <= '0;
            j_q         <= '0;
            out_valid_o <= 1'b0;
            t_o         <= '0;
            out_last_o  <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            done_o <= (state == DONE_WAIT) && out_xfer;
            if (out_xfer) begin
                out_valid_o <= 1'b0;
                out_last_o  <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        x_q  <= x_i;
                        np_q <= n_prime_0_i;
                        j_q  <= '0;
                    end
                end
                FIRST: begin
                    if (in_xfer) begin
                        m_q <= m_calc;
                        c_q <= c_nxt;
                        j_q <= JW'(1);
                    end
                end
                RUN, TOP: begin
                    if (in_xfer) begin
                        t_o         <= v[W-1:0];
                        c_q         <= c_nxt;
                        out_valid_o <= 1'b1;
                        out_last_o  <= 1'b0;
                        j_q         <= j_q + 1'b1;
                    end
                end
                FLUSH: begin
                    if (out_free) begin
                        t_o         <= c_q[W-1:0];
                        out_valid_o <= 1'b1;
                        out_last_o  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fios_pe_stream.sv
// Bench for fios_pe_stream: a W=4/S=2 and a W=16/S=16 instance share one stimulus
// path (selected by sel) and are checked against a big-integer Montgomery-step model.
module tb_fios_pe_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   sel = 1'b0;

    logic        start = 1'b0, in_valid = 1'b0, out_ready;
    logic [15:0] x_in = '0, np_in = '0, y_in = '0, n_in = '0, t_in = '0;

    logic       ir_s, ov_s, ol_s, busy_s, done_s;
    logic [3:0] to_s;
    logic        ir_l, ov_l, ol_l, busy_l, done_l;
    logic [15:0] to_l;

    logic        ir_m, ov_m, ol_m, busy_m, done_m;
    logic [15:0] to_m;

    int errors = 0;
    int checks = 0;

    logic [15:0] ya[0:16], na[0:16], ta[0:16], exp_w[0:16];
    logic [16:0] exp_q[$];

    int  rdy_mode = 0;
    bit  bp_arm   = 0;
    int  bp_cnt   = 0;
    bit  done_pend = 0;
    bit  stall_pend = 0;
    logic [15:0] stall_t;
    logic        stall_last;

    always #5 clk = ~clk;

    fios_pe_stream #(.W(4), .S(2)) dut_s (
        .clock_i(clk), .reset_i(rst), .start_i(start & ~sel),
        .x_i(x_in[3:0]), .n_prime_0_i(np_in[3:0]),
        .in_valid_i(in_valid & ~sel), .in_ready_o(ir_s),
        .y_i(y_in[3:0]), .n_i(n_in[3:0]), .t_i(t_in[3:0]),
        .out_valid_o(ov_s), .out_ready_i(out_ready), .t_o(to_s),
        .out_last_o(ol_s), .busy_o(busy_s), .done_o(done_s)
    );

    fios_pe_stream #(.W(16), .S(16)) dut_l (
        .clock_i(clk), .reset_i(rst), .start_i(start & sel),
        .x_i(x_in), .n_prime_0_i(np_in),
        .in_valid_i(in_valid & sel), .in_ready_o(ir_l),
        .y_i(y_in), .n_i(n_in), .t_i(t_in),
        .out_valid_o(ov_l), .out_ready_i(out_ready), .t_o(to_l),
        .out_last_o(ol_l), .busy_o(busy_l), .done_o(done_l)
    );

    assign ir_m   = sel ? ir_l   : ir_s;
    assign ov_m   = sel ? ov_l   : ov_s;
    assign ol_m   = sel ? ol_l   : ol_s;
    assign busy_m = sel ? busy_l : busy_s;
    assign done_m = sel ? done_l : done_s;
    assign to_m   = sel ? to_l   : {12'h000, to_s};

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // t' = (t + x*Y + m*n) >> w computed on whole multi-word integers.
    function automatic void model(input int w, input int s, input logic [15:0] x, input logic [15:0] np);
        logic [511:0] tb, yb, nb, sum, mask;
        logic [63:0]  u, m, wm;
        mask = (512'd1 << w) - 512'd1;
        wm   = (64'd1 << w) - 64'd1;
        tb = '0; yb = '0; nb = '0;
        for (int i = 0; i <= s; i++) tb = tb | (512'(ta[i]) << (w*i));
        for (int i = 0; i < s; i++) begin
            yb = yb | (512'(ya[i]) << (w*i));
            nb = nb | (512'(na[i]) << (w*i));
        end
        u   = 64'(ta[0]) + 64'(x) * 64'(ya[0]);
        m   = ((u & wm) * 64'(np)) & wm;
        sum = tb + 512'(x) * yb + 512'(m) * nb;
        chk("model_low_word_cancel", 32'(sum & mask), 32'd0);
        sum = sum >> w;
        for (int i = 0; i <= s; i++) exp_w[i] = 16'((sum >> (w*i)) & mask);
    endfunction

    function automatic logic [15:0] neg_inv(input logic [15:0] n0);
        logic [15:0] inv;
        inv = n0;
        for (int k = 0; k < 5; k++) inv = inv * (16'd2 - n0 * inv);
        return 16'd0 - inv;
    endfunction

    // Single compare process: output transfers against the model queue,
    // done_o every cycle, and held outputs under backpressure.
    always @(negedge clk) begin
        logic [16:0] e;
        if (rst) begin
            done_pend  = 0;
            stall_pend = 0;
        end else begin
            chk("done_o", done_m, done_pend);
            done_pend = 0;
            if (stall_pend) begin
                chk("hold_valid", ov_m, 1);
                chk("hold_t_o", to_m, stall_t);
                chk("hold_last", ol_m, stall_last);
            end
            stall_pend = 0;
            if (ov_m) begin
                if (!out_ready) begin
                    chk("bp_in_ready", ir_m, 0);
                    stall_pend = 1;
                    stall_t    = to_m;
                    stall_last = ol_m;
                end else if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", ov_m, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("t_o", to_m, e[15:0]);
                    chk("out_last_o", ol_m, e[16]);
                    if (e[16]) done_pend = 1;
                end
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (bp_arm && ov_m) begin
                        bp_arm = 0;
                        bp_cnt = 3;
                    end
                    if (bp_cnt > 0) begin
                        out_ready = 1'b0;
                        bp_cnt--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready_s"}, ir_s, 0);   chk({tag, "_in_ready_l"}, ir_l, 0);
        chk({tag, "_out_valid_s"}, ov_s, 0);  chk({tag, "_out_valid_l"}, ov_l, 0);
        chk({tag, "_t_o_s"}, to_s, 0);        chk({tag, "_t_o_l"}, to_l, 0);
        chk({tag, "_last_s"}, ol_s, 0);       chk({tag, "_last_l"}, ol_l, 0);
        chk({tag, "_busy_s"}, busy_s, 0);     chk({tag, "_busy_l"}, busy_l, 0);
        chk({tag, "_done_s"}, done_s, 0);     chk({tag, "_done_l"}, done_l, 0);
    endtask

    task automatic feed_beat(output int cyc);
        bit acc;
        cyc = 0;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = ir_m;
            chk("busy_during_beat", busy_m, 1);
            @(posedge clk); #1;
            cyc++;
        end while (!acc && cyc < 200);
        if (!acc) chk("beat_accept_timeout", acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy_m || done_pend) && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 2000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: pending=%0d busy=%0b expected 0 pending, not busy", exp_q.size(), busy_m);
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_start(input logic [15:0] x, input logic [15:0] np);
        start = 1'b1; x_in = x; np_in = np;
        @(posedge clk); #1;
        start = 1'b0; x_in = 16'($urandom); np_in = 16'($urandom);
    endtask

    task automatic run_iter(input bit big, input logic [15:0] x, input logic [15:0] np,
                            input int gmode, input bit bad_start);
        int s, w, cyc;
        s = big ? 16 : 2;
        w = big ? 16 : 4;
        wait_idle();
        sel = big;
        model(w, s, x, np);
        for (int i = 0; i <= s; i++) exp_q.push_back({(i == s), exp_w[i]});
        pulse_start(x, np);
        for (int j = 0; j <= s; j++) begin
            y_in = (j < s) ? ya[j] : 16'($urandom);
            n_in = (j < s) ? na[j] : 16'($urandom);
            t_in = ta[j];
            if (bad_start && j == 1) begin
                start = 1'b1;
                x_in  = ~x;
            end
            feed_beat(cyc);
            start = 1'b0;
            if (gmode == 0 && rdy_mode == 0) chk("full_rate_beat", cyc, 1);
            if (gmode != 0 && j < s) begin
                repeat ((gmode == 1) ? 1 : $urandom_range(0, 2)) begin
                    @(negedge clk);
                    chk("busy_during_gap", busy_m, 1);
                    @(posedge clk); #1;
                end
            end
        end
        wait_idle();
    endtask

    task automatic load_t1();
        ta[0] = 16'h0; ta[1] = 16'h0; ta[2] = 16'h0;
        ya[0] = 16'h3; ya[1] = 16'h1;
        na[0] = 16'hB; na[1] = 16'h2;
    endtask

    task automatic load_t2();
        ta[0] = 16'hF; ta[1] = 16'hF; ta[2] = 16'hF;
        ya[0] = 16'hF; ya[1] = 16'hF;
        na[0] = 16'hF; na[1] = 16'hF;
    endtask

    initial begin
        int cyc;
        logic [15:0] xr, npr;
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [15:0] xr;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Hand-derived words pin the model itself.
        load_t1();
        model(4, 2, 16'h5, 16'hD);
        chk("model_t1_w0", exp_w[0], 16'hE);
        chk("model_t1_w1", exp_w[1], 16'h0);
        chk("model_t1_w2", exp_w[2], 16'h0);
        load_t2();
        model(4, 2, 16'hF, 16'h1);
        chk("model_t2_w0", exp_w[0], 16'hF);
        chk("model_t2_w1", exp_w[1], 16'hE);
        chk("model_t2_w2", exp_w[2], 16'h1);

        rdy_mode = 0;
        load_t1(); run_iter(0, 16'h5, 16'hD, 0, 0);
        load_t2(); run_iter(0, 16'hF, 16'h1, 0, 0);

        rdy_mode = 2; bp_arm = 1;
        load_t1(); run_iter(0, 16'h5, 16'hD, 0, 0);
        rdy_mode = 0;

        load_t2(); run_iter(0, 16'hF, 16'h1, 1, 0);

        // Abort an iteration in RUN with an asynchronous reset.
        wait_idle();
        sel = 0;
        load_t1();
        pulse_start(16'h5, 16'hD);
        y_in = ya[0]; n_in = na[0]; t_in = ta[0];
        feed_beat(cyc);
        @(negedge clk);
        chk("pre_reset_busy", busy_m, 1);
        chk("pre_reset_in_ready", ir_m, 1);
        #1 rst = 1'b1;
        #1 check_reset_outputs("midrun_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        load_t1(); run_iter(0, 16'h5, 16'hD, 0, 0);

        load_t1(); run_iter(0, 16'h5, 16'hD, 0, 1);

        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i <= 16; i++) begin
                ya[i] = 16'($urandom);
                na[i] = 16'($urandom);
                ta[i] = 16'($urandom);
            end
            na[0][0] = 1'b1;
            if (it == 0) begin
                for (int i = 0; i <= 16; i++) begin
                    ya[i] = 16'hFFFF; na[i] = 16'hFFFF; ta[i] = 16'hFFFF;
                end
            end
            rdy_mode = (it < 3) ? 0 : int'($urandom_range(0, 1));
            xr = (it == 0) ? 16'hFFFF : 16'($urandom);
            run_iter(1, xr, neg_inv(na[0]), (it < 3) ? 0 : 2, (it % 7) == 5);
        end

        wait_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
